// File: rtl/inst_mem_resp.sv
// Instruction memory: loaded word-by-word in LOAD, serves registered fetches in RUN.
// Optional feature: define IMEM_PARITY_EN to store and check an even-parity bit per word.
module inst_mem_resp #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  input  logic                     reload,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic [31:0]              fetch_data,
  output logic                     fetch_valid,
  output logic                     fetch_err,
  output logic                     loaded,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     parity_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {LOAD, RUN} state_t;
  state_t state, state_nx;

  logic [31:0]    mem [DEPTH];
  logic [DEPTH-1:0] vbits;
  logic [AW-1:0]  wr_ptr;

  logic          accept, last_word, fetch_go;
  logic [AW-1:0] idx;
  logic          misal, oor, bad, hit;
  logic [31:0]   rd_word;

  assign accept    = (state == LOAD) && ld_valid && !reload;
  assign last_word = accept && (ld_last || wr_ptr == AW'(DEPTH - 1));
  assign fetch_go  = (state == RUN) && fetch_req && !reload;

  // Out-of-range is judged on the full word index, not just the bits used to address mem.
  assign idx     = fetch_addr[2 +: AW];
  assign misal   = |fetch_addr[1:0];
  assign oor     = {2'b00, fetch_addr[31:2]} >= 32'(DEPTH);
  assign bad     = misal || oor;
  assign hit     = !bad && vbits[idx];
  assign rd_word = mem[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (last_word) state_nx = RUN;
      RUN:  if (reload)    state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    ld_ready = (state == LOAD);
    loaded   = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      word_count <= '0;
      vbits      <= '0;
    end else if (reload) begin
      wr_ptr     <= '0;
      word_count <= '0;
      vbits      <= '0;
    end else if (accept) begin
      vbits[wr_ptr] <= 1'b1;
      wr_ptr        <= wr_ptr + AW'(1);
      if (word_count != CW'(DEPTH)) word_count <= word_count + CW'(1);
    end
  end

  // Array contents are not reset; the valid bits decide what is readable.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= ld_data;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_q;

  always_ff @(posedge clk) begin
    if (accept) par_mem[wr_ptr] <= ^ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        par_q <= 1'b0;
    else if (fetch_go) par_q <= hit && ((^rd_word) != par_mem[idx]);
  end

  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_data  <= NOP_WORD;
    end else begin
      fetch_valid <= fetch_go;
      if (fetch_go) begin
        fetch_data <= hit ? rd_word : NOP_WORD;
        fetch_err  <= bad;
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed self-checking bench for inst_mem_resp (default DEPTH=1024, NOP_WORD=0).
module tb_inst_mem_resp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_last, reload, fetch_req;
  logic [31:0] ld_data, fetch_addr;
  logic        ld_ready, fetch_valid, fetch_err, loaded, parity_err;
  logic [31:0] fetch_data;
  logic [10:0] word_count;

  int checks   = 0;
  int failures = 0;

  inst_mem_resp dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_err(fetch_err),
    .loaded(loaded), .word_count(word_count), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    #12;
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("rst_loaded", {31'b0, loaded}, 32'd0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_fetch_data", fetch_data, 32'h0);
    chk("rst_word_count", {21'b0, word_count}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Four-word image, ld_last on the fourth
    load_word(32'h11, 1'b0);
    chk("ld1_count", {21'b0, word_count}, 32'd1);
    chk("ld1_loaded", {31'b0, loaded}, 32'd0);
    load_word(32'h22, 1'b0);
    load_word(32'h33, 1'b0);
    chk("ld3_ready", {31'b0, ld_ready}, 32'd1);
    load_word(32'h44, 1'b1);
    chk("ld4_loaded", {31'b0, loaded}, 32'd1);
    chk("ld4_ready", {31'b0, ld_ready}, 32'd0);
    chk("ld4_count", {21'b0, word_count}, 32'd4);

    // Back-to-back fetches
    fetch_req = 1'b1; fetch_addr = 32'h0; tick();
    chk("f0_valid", {31'b0, fetch_valid}, 32'd1);
    chk("f0_data", fetch_data, 32'h11);
    fetch_addr = 32'h4; tick();
    chk("f4_valid", {31'b0, fetch_valid}, 32'd1);
    chk("f4_data", fetch_data, 32'h22);
    fetch_addr = 32'h8; tick();
    chk("f8_valid", {31'b0, fetch_valid}, 32'd1);
    chk("f8_data", fetch_data, 32'h33);
    chk("f8_err", {31'b0, fetch_err}, 32'd0);
    fetch_req = 1'b0; tick();
    chk("idle_valid", {31'b0, fetch_valid}, 32'd0);
    chk("idle_hold", fetch_data, 32'h33);
    chk("run_count_hold", {21'b0, word_count}, 32'd4);

    // Bad and unwritten fetches
    fetch(32'h2);
    chk("mis_valid", {31'b0, fetch_valid}, 32'd1);
    chk("mis_data", fetch_data, 32'h0);
    chk("mis_err", {31'b0, fetch_err}, 32'd1);
    fetch(32'hC);
    chk("fC_data", fetch_data, 32'h44);
    chk("fC_err", {31'b0, fetch_err}, 32'd0);
    fetch(32'h1000);
    chk("oor_data", fetch_data, 32'h0);
    chk("oor_err", {31'b0, fetch_err}, 32'd1);
    tick();
    chk("err_hold", {31'b0, fetch_err}, 32'd1);
    fetch(32'h10);
    chk("unwr_data", fetch_data, 32'h0);
    chk("unwr_err", {31'b0, fetch_err}, 32'd0);
    chk("par_default", {31'b0, parity_err}, 32'd0);
    fetch(32'h4);

    // reload with simultaneous fetch
    reload = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0; tick();
    reload = 1'b0; fetch_req = 1'b0;
    chk("rl_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rl_loaded", {31'b0, loaded}, 32'd0);
    chk("rl_ready", {31'b0, ld_ready}, 32'd1);
    chk("rl_count", {21'b0, word_count}, 32'd0);
    chk("rl_hold", fetch_data, 32'h22);

    // One-word image while a fetch is requested (ignored in LOAD)
    fetch_req = 1'b1; fetch_addr = 32'h0;
    load_word(32'hAA, 1'b1);
    fetch_req = 1'b0;
    chk("ldf_valid", {31'b0, fetch_valid}, 32'd0);
    chk("ldf_loaded", {31'b0, loaded}, 32'd1);
    chk("ldf_count", {21'b0, word_count}, 32'd1);
    fetch(32'h4);
    chk("stale_data", fetch_data, 32'h0);
    chk("stale_err", {31'b0, fetch_err}, 32'd0);
    fetch(32'h0);
    chk("aa_data", fetch_data, 32'hAA);

    // reload in LOAD drops the same-cycle word
    reload = 1'b1; tick(); reload = 1'b0;
    reload = 1'b1; ld_valid = 1'b1; ld_data = 32'h55; tick();
    reload = 1'b0; ld_valid = 1'b0;
    chk("rlld_count", {21'b0, word_count}, 32'd0);
    load_word(32'h66, 1'b0);
    load_word(32'h77, 1'b0);
    chk("part_count", {21'b0, word_count}, 32'd2);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", {21'b0, word_count}, 32'd0);
    chk("arst_data", fetch_data, 32'h0);
    chk("arst_ready", {31'b0, ld_ready}, 32'd1);
    #1 rst_n = 1'b1;
    tick();
    load_word(32'h99, 1'b1);
    chk("post_loaded", {31'b0, loaded}, 32'd1);
    fetch(32'h0);
    chk("post_f0", fetch_data, 32'h99);
    fetch(32'h4);
    chk("post_f4", fetch_data, 32'h0);

`ifdef IMEM_PARITY_EN
    dut.mem[0][3] = ~dut.mem[0][3];
    fetch(32'h0);
    chk("par_err", {31'b0, parity_err}, 32'd1);
    chk("par_data", fetch_data, 32'h91);
`else
    fetch(32'h0);
    chk("par_zero", {31'b0, parity_err}, 32'd0);
`endif

    // Fill to DEPTH without ld_last: leaves LOAD on the last slot, count saturates
    reload = 1'b1; tick(); reload = 1'b0;
    for (int i = 0; i < 1023; i++) load_word(32'h1000 + i, 1'b0);
    chk("fill_1023_count", {21'b0, word_count}, 32'd1023);
    chk("fill_1023_loaded", {31'b0, loaded}, 32'd0);
    load_word(32'h1000 + 1023, 1'b0);
    chk("fill_loaded", {31'b0, loaded}, 32'd1);
    chk("fill_count", {21'b0, word_count}, 32'd1024);
    fetch(32'hFFC);
    chk("fill_last_data", fetch_data, 32'h13FF);
    chk("fill_last_err", {31'b0, fetch_err}, 32'd0);
    tick();
    chk("fill_count_hold", {21'b0, word_count}, 32'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit instruction words.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, word returned for invalid fetches.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ld_valid  input  1  load word present.
REQ-006 SHALL have port ld_data  input  32  load instruction word.
REQ-007 SHALL have port ld_last  input  1  marks final load word.
REQ-008 SHALL have port ld_ready  output  1  block accepts a load word.
REQ-009 SHALL have port reload  input  1  one-cycle request to re-enter load mode.
REQ-010 SHALL have port fetch_req  input  1  fetch stage requests a word.
REQ-011 SHALL have port fetch_addr  input  32  byte PC from the fetch stage.
REQ-012 SHALL have port fetch_data  output  32  registered instruction word.
REQ-013 SHALL have port fetch_valid  output  1  fetch_data valid this cycle.
REQ-014 SHALL have port fetch_err  output  1  last fetch was misaligned or out of range.
REQ-015 SHALL have port loaded  output  1  high in RUN state.
REQ-016 SHALL have port word_count  output  $clog2(DEPTH)+1  words written in the current load.
REQ-017 SHALL have port parity_err  output  1  stored-word parity mismatch on last fetch.

Function
REQ-018 SHALL implement states LOAD and RUN; reset enters LOAD.
REQ-019 In LOAD, ld_ready SHALL be 1; each cycle with ld_valid=1 SHALL write ld_data to mem[wr_ptr] and increment wr_ptr and word_count.
REQ-020 LOAD->RUN SHALL occur on the cycle after an accepted word with ld_last=1 or with wr_ptr=DEPTH-1; ld_ready SHALL be 0 in RUN.
REQ-021 In LOAD, fetch_req SHALL be ignored: fetch_valid=0, fetch_data holds its value.
REQ-022 In RUN, fetch_req=1 at edge N SHALL give fetch_valid=1 and fetch_data=mem[fetch_addr[2+:$clog2(DEPTH)]] after edge N; fetch_valid=0 otherwise (1-cycle latency, back-to-back each cycle).
REQ-023 Fetch with fetch_addr[1:0]!=0 or word index >= DEPTH SHALL return NOP_WORD with fetch_valid=1 and fetch_err=1; fetch_err SHALL be 0 on every good fetch and update only with fetch_valid.
REQ-024 Words never written in the current load SHALL read as NOP_WORD (per-word valid bits cleared on entering LOAD).
REQ-025 reload=1 in RUN SHALL move to LOAD next cycle, clear wr_ptr, word_count and valid bits; a same-cycle fetch_req SHALL be dropped (fetch_valid=0).
REQ-026 reload in LOAD SHALL restart at wr_ptr=0 and drop any same-cycle load word.
REQ-027 word_count SHALL saturate at DEPTH and hold its value in RUN.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=LOAD, wr_ptr=0, word_count=0, valid bits=0, ld_ready=1, loaded=0, fetch_valid=0, fetch_err=0, parity_err=0, fetch_data=NOP_WORD.
REQ-029 Reset mid-load SHALL discard the partial image; memory array contents need not be cleared.

Configuration
REQ-030 With IMEM_PARITY_EN defined, each word SHALL store an even-parity bit written at load; a fetch whose recomputed parity mismatches SHALL set parity_err=1 with fetch_valid, returning the stored word.
REQ-031 Without IMEM_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be constant 0.

Verification
REQ-032 Load 4 words 0x11,0x22,0x33,0x44 (last on 4th) -> ld_ready drops and loaded=1 on the following cycle; word_count=4.
REQ-033 RUN, fetch_req with addr 0x0,0x4,0x8 on consecutive cycles -> fetch_valid 3 cycles, data 0x11,0x22,0x33 one cycle later each.
REQ-034 Fetch addr 0x2 and addr 0x1000 (DEPTH=1024) -> fetch_data=0x0, fetch_err=1; fetch addr 0x10 (unwritten) -> 0x0, fetch_err=0.
REQ-035 reload with simultaneous fetch_req -> no fetch_valid, loaded=0, ld_ready=1, word_count=0; fetch of 0x4 after 1-word reload -> 0x0.
REQ-036 Assert rst_n=0 mid-cycle after 2 of 4 load words -> outputs reach reset values immediately without a clock edge; subsequent load starts at address 0.
REQ-037 IMEM_PARITY_EN build: force-flip a stored bit, fetch it -> parity_err=1; non-parity build -> parity_err stays 0.
